oled_spi_monitor: RTL and testbench

- SPI receiving end of the SSD1306 OLED link: samples CS/SCLK/SDIN/DC driven by the display controller and decodes the byte stream as the panel would.
- Decodes commands and arguments, tracks display state, and writes data bytes into a 512-byte shadow frame buffer (4 pages x 128 columns) with a read port.
- Used as a bench/board-level mirror of what the panel receives, so display updates can be checked without a physical screen.

---
 rtl/oled_spi_monitor.sv | 229 ++++++++++++++++++++++
 tb/tb_oled_spi_monitor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/oled_spi_monitor.sv
// SSD1306 SPI receive-side monitor: decodes the command/data stream and mirrors the 4x128 frame buffer.
// Optional sticky error flags and err_clr are enabled by defining OLED_MON_ERR_EN.
module oled_spi_monitor #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sclk,
  input  logic       sdin,
  input  logic       dc,
  input  logic [8:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data,
  output logic       disp_on,
  output logic       entire_on,
  output logic [7:0] contrast,
  output logic [1:0] cur_page,
  output logic [6:0] cur_col
`ifdef OLED_MON_ERR_EN
  ,
  input  logic       err_clr,
  output logic       err_partial,
  output logic       err_arg_abort,
  output logic       err_overrun
`endif
);

  typedef enum logic [1:0] {ST_CMD, ST_ARG1, ST_ARG2} state_t;

  logic [SYNC_STAGES-1:0] cs_q, sclk_q, sdin_q, dc_q;
  logic                   sclk_prev;
  logic                   cs_s, sclk_s, sdin_s, dc_s, rise;

  logic [6:0] shreg;
  logic [2:0] bitcnt;

  state_t     state, state_nx;
  logic [7:0] opcode;
  logic       takes_arg, two_args;
  logic       horiz;
  logic [1:0] page_start, page_end;
  logic [6:0] col_start, col_end;

  logic [7:0] mem [512];
  logic       we;
  logic [8:0] waddr;

  assign cs_s   = cs_q[SYNC_STAGES-1];
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign sdin_s = sdin_q[SYNC_STAGES-1];
  assign dc_s   = dc_q[SYNC_STAGES-1];
  assign rise   = ~sclk_prev & sclk_s;

  // Sync flops reset to the idle bus (cs high, sclk high) so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q      <= '1;
      sclk_q    <= '1;
      sdin_q    <= '0;
      dc_q      <= '0;
      sclk_prev <= 1'b1;
    end else begin
      cs_q      <= {cs_q[SYNC_STAGES-2:0], cs};
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk};
      sdin_q    <= {sdin_q[SYNC_STAGES-2:0], sdin};
      dc_q      <= {dc_q[SYNC_STAGES-2:0], dc};
      sclk_prev <= sclk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg        <= '0;
      bitcnt       <= '0;
      byte_valid   <= 1'b0;
      byte_data    <= '0;
      byte_is_data <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_s) begin
        bitcnt <= '0;
      end else if (rise) begin
        shreg  <= {shreg[5:0], sdin_s};
        bitcnt <= bitcnt + 3'd1;
        if (bitcnt == 3'd7) begin
          byte_valid   <= 1'b1;
          byte_data    <= {shreg, sdin_s};
          byte_is_data <= dc_s;
        end
      end
    end
  end

  always_comb begin
    takes_arg = byte_data inside {8'h81, 8'h20, 8'h8D, 8'hA8, 8'hD3, 8'hD5,
                                  8'hD9, 8'hDA, 8'hDB, 8'h21, 8'h22};
    two_args  = (opcode == 8'h21) || (opcode == 8'h22);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_CMD;
    else     state <= state_nx;
  end

  // A data byte always drops back to CMD, aborting any pending argument sequence.
  always_comb begin
    state_nx = state;
    if (byte_valid) begin
      if (byte_is_data) begin
        state_nx = ST_CMD;
      end else begin
        case (state)
          ST_CMD:  state_nx = takes_arg ? ST_ARG1 : ST_CMD;
          ST_ARG1: state_nx = two_args ? ST_ARG2 : ST_CMD;
          default: state_nx = ST_CMD;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode     <= '0;
      disp_on    <= 1'b0;
      entire_on  <= 1'b0;
      contrast   <= 8'h7F;
      cur_page   <= '0;
      cur_col    <= '0;
      horiz      <= 1'b0;
      page_start <= 2'd0;
      page_end   <= 2'd3;
      col_start  <= 7'd0;
      col_end    <= 7'd127;
    end else if (byte_valid) begin
      if (byte_is_data) begin
        if (horiz) begin
          if (cur_col == col_end) begin
            cur_col  <= col_start;
            cur_page <= (cur_page == page_end) ? page_start : cur_page + 2'd1;
          end else begin
            cur_col <= cur_col + 7'd1;
          end
        end else begin
          cur_col <= cur_col + 7'd1;
        end
      end else begin
        case (state)
          ST_CMD: begin
            if (byte_data[7:4] == 4'h0)          cur_col[3:0] <= byte_data[3:0];
            else if (byte_data[7:3] == 5'b00010) cur_col[6:4] <= byte_data[2:0];
            else if (byte_data[7:3] == 5'b00011) cur_col      <= 7'd127;
            else begin
              case (byte_data)
                8'hAE:   disp_on   <= 1'b0;
                8'hAF:   disp_on   <= 1'b1;
                8'hA4:   entire_on <= 1'b0;
                8'hA5:   entire_on <= 1'b1;
                default: ;
              endcase
            end
            if (takes_arg) opcode <= byte_data;
          end
          ST_ARG1: begin
            case (opcode)
              8'h81: contrast <= byte_data;
              8'h20: begin
                if (byte_data[1:0] == 2'b00)      horiz <= 1'b1;
                else if (byte_data[1:0] == 2'b10) horiz <= 1'b0;
              end
              8'h22: begin
                page_start <= byte_data[1:0];
                cur_page   <= byte_data[1:0];
              end
              8'h21: begin
                col_start <= byte_data[6:0];
                cur_col   <= byte_data[6:0];
              end
              default: ;
            endcase
          end
          ST_ARG2: begin
            case (opcode)
              8'h22:   page_end <= byte_data[1:0];
              8'h21:   col_end  <= byte_data[6:0];
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign we    = byte_valid & byte_is_data;
  assign waddr = {cur_page, cur_col};

  // Frame buffer is deliberately not reset; read-first on address collision.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= byte_data;
    rd_data <= mem[rd_addr];
  end

`ifdef OLED_MON_ERR_EN
  logic [1:0] gap;

  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_partial   <= 1'b0;
      err_arg_abort <= 1'b0;
      err_overrun   <= 1'b0;
    end else begin
      if (cs_s && bitcnt != 3'd0) err_partial <= 1'b1;
      if (byte_valid && byte_is_data && state != ST_CMD) err_arg_abort <= 1'b1;
      if (rise && gap <= 2'd2) err_overrun <= 1'b1;
    end
  end

  // gap = clk cycles since the previous detected rise, saturating at 3.
  always_ff @(posedge clk) begin
    if (rst)              gap <= 2'd3;
    else if (rise)        gap <= 2'd1;
    else if (gap != 2'd3) gap <= gap + 2'd1;
  end
`endif

endmodule

// File: tb/tb_oled_spi_monitor.sv
// Directed bench for oled_spi_monitor: commands, page/horizontal writes, partial-byte discard, argument abort, reset.
module tb_oled_spi_monitor;

  logic       clk = 1'b0;
  logic       rst, cs, sclk, sdin, dc;
  logic [8:0] rd_addr;
  logic [7:0] rd_data;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_is_data;
  logic       disp_on, entire_on;
  logic [7:0] contrast;
  logic [1:0] cur_page;
  logic [6:0] cur_col;

  int vectors = 0;
  int miscompares = 0;
  int n_strobe = 0;
  int n_data_strobe = 0;

  oled_spi_monitor #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .sdin(sdin), .dc(dc),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_data(byte_is_data),
    .disp_on(disp_on), .entire_on(entire_on), .contrast(contrast),
    .cur_page(cur_page), .cur_col(cur_col)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (byte_valid) begin
      n_strobe++;
      if (byte_is_data) n_data_strobe++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    cs = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      sclk = 1'b0; sdin = b[i]; dc = d;
      #40;
      sclk = 1'b1;
      #40;
    end
    #60;
  endtask

  task automatic read_buf(input logic [8:0] a, output logic [7:0] v);
    rd_addr = a;
    #20;
    v = rd_data;
  endtask

  logic [7:0] v;
  int s0, d0;

  initial begin
    rst = 1'b1; cs = 1'b1; sclk = 1'b1; sdin = 1'b0; dc = 1'b0; rd_addr = '0;
    #50;
    rst = 1'b0;
    #20;
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_data", byte_data, 8'h00);
    check("rst_byte_is_data", byte_is_data, 0);
    check("rst_disp_on", disp_on, 0);
    check("rst_entire_on", entire_on, 0);
    check("rst_contrast", contrast, 8'h7F);
    check("rst_page", cur_page, 0);
    check("rst_col", cur_col, 0);

    // AF A5 81 3C
    s0 = n_strobe; d0 = n_data_strobe;
    send_byte(8'hAF, 0); send_byte(8'hA5, 0); send_byte(8'h81, 0); send_byte(8'h3C, 0);
    check("cmd_disp_on", disp_on, 1);
    check("cmd_entire_on", entire_on, 1);
    check("cmd_contrast", contrast, 8'h3C);
    check("cmd_strobes", n_strobe - s0, 4);
    check("cmd_data_strobes", n_data_strobe - d0, 0);
    check("cmd_byte_data", byte_data, 8'h3C);
    check("cmd_byte_is_data", byte_is_data, 0);

    // Page range 2..3, col 0, two data bytes
    send_byte(8'h22, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    send_byte(8'h00, 0); send_byte(8'h10, 0);
    send_byte(8'hAA, 1); send_byte(8'h55, 1);
    check("pg_col", cur_col, 2);
    check("pg_page", cur_page, 2);
    check("pg_byte_is_data", byte_is_data, 1);
    read_buf(9'h100, v); check("pg_buf100", v, 8'hAA);
    read_buf(9'h101, v); check("pg_buf101", v, 8'h55);

    // Page mode wrap at col 127 on page 1
    send_byte(8'h22, 0); send_byte(8'h01, 0); send_byte(8'h03, 0);
    send_byte(8'h0F, 0); send_byte(8'h17, 0);
    check("wrap_col_set", cur_col, 127);
    send_byte(8'h11, 1); send_byte(8'h22, 1);
    check("wrap_page", cur_page, 1);
    check("wrap_col", cur_col, 1);
    read_buf(9'h0FF, v); check("wrap_buf0ff", v, 8'h11);
    read_buf(9'h080, v); check("wrap_buf080", v, 8'h22);

    // Column clamp opcode
    send_byte(8'h1B, 0);
    check("clamp_col", cur_col, 127);

    // Horizontal mode full-screen fill
    send_byte(8'h20, 0); send_byte(8'h00, 0);
    send_byte(8'h21, 0); send_byte(8'h00, 0); send_byte(8'h7F, 0);
    send_byte(8'h22, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
    check("h_start_page", cur_page, 0);
    check("h_start_col", cur_col, 0);
    for (int i = 0; i < 512; i++) send_byte(8'(i), 1);
    check("h_end_page", cur_page, 0);
    check("h_end_col", cur_col, 0);
    for (int i = 0; i < 512; i++) begin
      read_buf(9'(i), v);
      check("h_buf", v, i[7:0]);
    end

    // Partial byte discarded on cs high
    s0 = n_strobe;
    cs = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b0; sdin = 1'b1; dc = 1'b0; #40; sclk = 1'b1; #40;
    end
    cs = 1'b1;
    #100;
    send_byte(8'hAE, 0);
    check("partial_strobes", n_strobe - s0, 1);
    check("partial_byte", byte_data, 8'hAE);
    check("partial_disp_on", disp_on, 0);

    // Argument aborted by data byte
    send_byte(8'h81, 0);
    send_byte(8'h77, 1);
    check("abort_contrast", contrast, 8'h3C);
    check("abort_col", cur_col, 1);
    read_buf(9'h000, v); check("abort_buf000", v, 8'h77);
    send_byte(8'hAF, 0);
    check("abort_cmd_disp_on", disp_on, 1);
    check("abort_cmd_contrast", contrast, 8'h3C);

    // Reset mid-byte
    cs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b0; sdin = 1'b1; dc = 1'b0; #40; sclk = 1'b1; #40;
    end
    rst = 1'b1;
    #30;
    rst = 1'b0;
    #30;
    check("mid_rst_disp_on", disp_on, 0);
    check("mid_rst_contrast", contrast, 8'h7F);
    check("mid_rst_col", cur_col, 0);
    check("mid_rst_byte_data", byte_data, 8'h00);
    send_byte(8'hA5, 0);
    check("post_rst_entire_on", entire_on, 1);
    check("post_rst_byte", byte_data, 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
